// File: rtl/fp_posit_acc_pipe.sv
// Pipelined aligned accumulator: aligns sign/exponent/fraction terms to a shared
// exponent, sums a programmed number of them with saturation, then hands the result off.
module fp_posit_acc_pipe #(
  parameter int ACC_W = 32,
  parameter int IN_W  = 14,
  parameter int EXP_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [EXP_W-1:0] exp_set,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [IN_W-1:0]  frac_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [EXP_W-1:0] exp_out,
  output logic             overflow,
  output logic             busy
);

  // Wide enough to hold the largest left shift without losing bits, and at least ACC_W+1.
  localparam int SHW = ((IN_W + (1 << EXP_W)) > ACC_W) ? (IN_W + (1 << EXP_W)) : (ACC_W + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                   state, nstate;
  logic signed [ACC_W-1:0]  acc;
  logic [EXP_W-1:0]         exp_lat;
  logic [CNT_W-1:0]         num_lat;
  logic [CNT_W-1:0]         cnt;
  logic                     ovf_r;

  logic [ACC_W-1:0]         aligned_p0;
  logic                     sign_p0;
  logic                     sat_p0;
  logic                     vld_p0;
  logic                     vld_p1;

  logic                     accept;
  logic                     last_term;
  logic [ACC_W-1:0]         aligned_s1;
  logic                     sat_s1;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic                     add_ovf;

  // Returns {saturated, magnitude}; magnitude always fits below the accumulator sign bit.
  function automatic logic [ACC_W:0] align_term(input logic [IN_W-1:0]  frac,
                                                input logic [EXP_W-1:0] e,
                                                input logic [EXP_W-1:0] eset);
    logic signed [EXP_W:0] diff;
    logic [EXP_W:0]        rshift;
    logic [SHW-1:0]        wide;
    logic [ACC_W-1:0]      res;
    logic                  sat;
    diff   = signed'({1'b0, e}) - signed'({1'b0, eset});
    rshift = '0;
    wide   = '0;
    res    = '0;
    sat    = 1'b0;
    if (diff >= 0) begin
      wide = {{(SHW-IN_W){1'b0}}, frac} << diff[EXP_W-1:0];
      if (|wide[SHW-1:ACC_W-1]) begin
        sat = 1'b1;
        res = {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        res = wide[ACC_W-1:0];
      end
    end else begin
      rshift = unsigned'(-diff);
      if (int'(rshift) < IN_W)
        res = ACC_W'(frac >> rshift);
    end
    return {sat, res};
  endfunction

  // Returns {clamped, result}; ACC_W+1 bits are enough since the magnitude is below 2^(ACC_W-1).
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0]        mag,
                                             input logic                    sub);
    logic signed [ACC_W:0] sum;
    logic [ACC_W-1:0]      res;
    logic                  clamp;
    if (sub)
      sum = {a[ACC_W-1], a} - signed'({1'b0, mag});
    else
      sum = {a[ACC_W-1], a} + signed'({1'b0, mag});
    clamp = sum[ACC_W] ^ sum[ACC_W-1];
    if (!clamp)
      res = sum[ACC_W-1:0];
    else if (sum[ACC_W])
      res = {1'b1, {(ACC_W-1){1'b0}}};
    else
      res = {1'b0, {(ACC_W-1){1'b1}}};
    return {clamp, res};
  endfunction

  assign accept    = in_valid & in_ready;
  assign last_term = accept && (cnt == num_lat - 1'b1);

  always_comb begin
    {sat_s1, aligned_s1} = align_term(frac_in, exp_in, exp_lat);
    {add_ovf, acc_nxt}   = sat_add(acc, aligned_p0, sign_p0);
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = (num_terms == '0) ? DONE : ACCUM;
      ACCUM:   if (last_term) nstate = DRAIN;
      DRAIN:   if (!vld_p0 && !vld_p1) nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM) && (cnt < num_lat);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Stage 1: alignment, registered on the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      aligned_p0 <= aligned_s1;
      sat_p0     <= sat_s1;
      sign_p0    <= sign_in;
    end
  end

  // Stage 2: saturating accumulate, plus control and latched operands
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      exp_lat <= '0;
      num_lat <= '0;
      cnt     <= '0;
      ovf_r   <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
      if (accept)
        cnt <= cnt + 1'b1;
      if (state == IDLE && start) begin
        exp_lat <= exp_set;
        num_lat <= num_terms;
        acc     <= '0;
        ovf_r   <= 1'b0;
        cnt     <= '0;
      end else if (vld_p0) begin
        acc   <= acc_nxt;
        ovf_r <= ovf_r | sat_p0 | add_ovf;
      end
    end
  end

  assign acc_out  = acc;
  assign exp_out  = exp_lat;
  assign overflow = ovf_r;

endmodule

// File: doc/fp_posit_acc_pipe.md
Name: fp_posit_acc_pipe

Overview:
- Parametrised, pipelined successor to the single-shot aligned accumulator in the FP/posit MAC datapath.
- Accepts a stream of sign/exponent/fraction products over a valid/ready handshake and aligns each one to a shared exponent.
- Accumulates a programmed number of terms into a saturating two's-complement register, then presents the result through an output handshake.
- Sits between the multiplier stage and the posit encoder.

Parameters:
- ACC_W, 32, accumulator width in bits (two's complement).
- IN_W, 14, unsigned fraction input width.
- EXP_W, 5, unsigned exponent width.
- CNT_W, 8, width of the term-count field.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  begin new accumulation; honoured only in IDLE.
- exp_set  input  EXP_W  shared target exponent; latched on start.
- num_terms  input  CNT_W  terms to accumulate; latched on start.
- in_valid  input  1  term present on sign_in/exp_in/frac_in.
- in_ready  output  1  block can accept a term.
- sign_in  input  1  1 = subtract term.
- exp_in  input  EXP_W  term exponent.
- frac_in  input  IN_W  term magnitude.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- acc_out  output  ACC_W  accumulated result.
- exp_out  output  EXP_W  latched exp_set.
- overflow  output  1  sticky saturation flag for the current accumulation.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - acc_out, exp_out, overflow, out_valid, in_ready, busy and all pipeline valids go to 0.
  - Reset takes priority over every other event, including mid-accumulation; in-flight terms are discarded.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - On start, latch exp_set and num_terms, clear acc to 0, clear overflow, clear the accepted count.
  - Go to ACCUM, or to DONE if num_terms=0.
- ACCUM:
  - in_ready=1 while accepted count < num_terms.
  - A term is accepted when in_valid & in_ready at a clock edge.
  - On the edge accepting term number num_terms, go to DRAIN; in_ready is 0 from then on.
- DRAIN: wait until both pipeline stages are empty, then go to DONE.
- DONE:
  - out_valid=1; acc_out and exp_out are held stable.
  - On out_valid & out_ready, go to IDLE and drop out_valid.
- start outside IDLE is ignored.
- Stage 1 (alignment), registered on the accept edge:
  - diff = exp_in − exp_set, computed signed in EXP_W+1 bits, so there is no wrap-around.
  - diff=0: aligned = frac_in.
  - diff>0: aligned = frac_in << diff. If any set bit would land at or above bit ACC_W−1, aligned saturates to 2^(ACC_W−1)−1 and sets overflow.
  - diff<0: aligned = frac_in >> −diff, truncating. If −diff ≥ IN_W, aligned = 0.
  - sign_in is carried with the term through the pipeline (no sign skew).
- Stage 2 (accumulation), one edge after stage 1:
  - acc ± aligned, computed in ACC_W+1 bits.
  - Result above 2^(ACC_W−1)−1 clamps to that value; below −2^(ACC_W−1) clamps to that value. Either clamp sets overflow.
- Latency:
  - out_valid rises at the 3rd edge after the edge accepting the last term: align, accumulate, state update.
  - num_terms=0: out_valid rises at the edge after start.
- Throughput: one term per cycle; a gap in in_valid stalls nothing downstream.
- overflow is sticky until the next honoured start or reset.

Test Plan:
- Basic alignment: ACC_W=32, IN_W=14, EXP_W=5; start exp_set=10, num_terms=3; terms (+,12,3), (+,10,100), (−,9,40) back-to-back -> acc_out=92 (12+100−20), exp_out=10, overflow=0, out_valid 3 edges after the 3rd accept.
- Exponent extremes: exp_set=3; terms (+,30,16383), (+,2,5) -> first term saturates, overflow=1, acc_out=0x7FFFFFFF (+0 for the second term, since 5>>1=2 gives 0x7FFFFFFF after clamp). Separately, exp_set=20, exp_in=2 -> aligned=0, overflow=0.
- Negative saturation: exp_set=0; 4 terms (−,18,16383) -> acc_out=0x80000000, overflow=1.
- Handshake:
  - in_valid toggling 1,0,0,1,1 with 3 terms (+,5,1) at exp_set=5 -> acc_out=3.
  - out_ready held 0 for 5 cycles -> out_valid and acc_out stable; start pulsed during DONE is ignored; out_ready=1 -> IDLE next edge.
- Zero terms: start with num_terms=0 -> out_valid at the next edge, acc_out=0, in_ready never asserted.
- Reset mid-operation: assert rst after the 2nd of 4 terms -> next edge all outputs 0, state IDLE. A subsequent start with 1 term (+,exp_set,7) -> acc_out=7, with no residue from before reset.
